ex_iter_div: RTL and testbench
==============================

# ex_iter_div

Parametrised iterative radix-2 divider for the EX stage. It replaces the fixed 32-bit start/done divider with a width-generic datapath, a valid/ready handshake on both sides, a pass-through tag, flush support, early-out and a defined divide-by-zero result. It produces quotient and remainder together; EX selects the one it needs and holds `advance_ready` low until `out_valid`.

## Interface

Parameters:
- `DATA_WIDTH`, default 32: operand and result width; must be ≥ 2.
- `TAG_WIDTH`, default 4: width of the opaque tag (e.g. FTQ id / ROB slot) carried with the request.
- `EARLY_OUT`, default 1: 1 enables the 1-cycle shortcut when |dividend| < |divisor|.

Ports:
- `clk`  in  1  clock. One clock; reset is asynchronous and active-low.
- `rst`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous kill; highest priority after reset.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  unit can accept a request.
- `in_signed`  in  1  1 = signed (two's complement), 0 = unsigned.
- `in_dividend`  in  DATA_WIDTH  dividend.
- `in_divisor`  in  DATA_WIDTH  divisor.
- `in_tag`  in  TAG_WIDTH  tag returned with the result.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer takes the result.
- `out_quotient`  out  DATA_WIDTH  quotient.
- `out_remainder`  out  DATA_WIDTH  remainder.
- `out_tag`  out  TAG_WIDTH  tag of the result.
- `out_div_by_zero`  out  1  the divisor was 0.
- `busy`  out  1  high in every state except IDLE.

## Operation

- States: IDLE, CALC, FIX, DONE. Reset value is IDLE.
- **IDLE**
  - `in_ready` = 1.
  - Accept on `in_valid & in_ready & ~flush`.
  - On accept, latch the op, tag and original dividend, plus the sign flags: dividend negative (`sd`) and divisor negative (`sv`), both only when signed.
  - Latch the magnitudes |a| and |b| as DATA_WIDTH-bit unsigned values. The magnitude of the most negative value is 2^(W-1), which is representable unsigned.
- **Accept-cycle decision**
  - Divisor == 0: go to DONE with quotient = all ones, remainder = original dividend, `out_div_by_zero` = 1. This applies regardless of `EARLY_OUT`.
  - Else if `EARLY_OUT` and |a| < |b|: go to DONE with quotient = 0, remainder = original dividend.
  - Otherwise: go to CALC with partial remainder = 0, quotient shift register = |a|, counter = 0.
- **CALC** (one iteration per cycle)
  - Shift {rem, q} left by 1; form trial = rem_shifted − |b| using DATA_WIDTH+1 bits.
  - If the trial is non-negative, rem = trial and the shifted-in q bit = 1; otherwise keep rem and the shifted-in bit = 0.
  - Counter is $clog2(DATA_WIDTH)+1 bits wide.
  - After the iteration with counter == DATA_WIDTH−1, go to FIX.
- **FIX**
  - Quotient is negated if signed & (`sd` ^ `sv`).
  - Remainder is negated if signed & `sd`.
  - The remainder sign follows the dividend.
  - Next state is DONE.
- **DONE**
  - `out_valid` = 1 with all result outputs stable.
  - On `out_ready`, go to IDLE.
  - No new request is accepted in DONE.
- **Overflow**: most-negative ÷ −1 yields quotient = most-negative value and remainder = 0. This falls out of the datapath; no special case is added.
- **flush**
  - Any state goes to IDLE on the next edge.
  - The result is discarded and `out_valid` is low the following cycle.
  - Flush in IDLE together with `in_valid` accepts nothing.
  - Flush in DONE together with `out_ready` is still treated as a flush; the consumer must ignore the result.
- **Reset** (asynchronous, may arrive mid-operation)
  - State goes to IDLE immediately.
  - All output registers go to 0: `out_valid`, `out_quotient`, `out_remainder`, `out_tag`, `out_div_by_zero`, `busy`.
  - `in_ready` is 1 while in reset-released IDLE.

## Timing

- All outputs are registered or decoded from the state register. There is no combinational path from any `in_*` input to any `out_*` output.
- `in_ready` = (state == IDLE); it does not depend on `out_ready`.
- Full-path latency: accept edge t → CALC for cycles t+1..t+W → FIX at t+W+1 → `out_valid` at t+W+2. For W = 32, latency is 34 cycles.
- Shortcut latency (div-by-zero or early-out): `out_valid` in the cycle after the accept.
- Back-to-back throughput: the result is taken on edge k (IDLE at k+1), and the next accept can happen at k+1.
- Backpressure: with `out_ready` low, DONE holds for any number of cycles and the result does not change.

## Test plan

- **Unsigned full path** (W=32): 100 ÷ 7 → q=14, r=2, `out_valid` exactly 34 cycles after accept, `out_tag` equals the request tag. Also 0xFFFFFFFF ÷ 1 → q=0xFFFFFFFF, r=0.
- **Signed full path**: −7 ÷ 2 → q=0xFFFFFFFD, r=0xFFFFFFFF. Also 7 ÷ −2 → q=0xFFFFFFFD, r=1. Also 0x80000000 ÷ 0xFFFFFFFF → q=0x80000000, r=0.
- **Shortcuts**: 5 ÷ 0 → q=0xFFFFFFFF, r=5, `out_div_by_zero`=1, latency 1. With `EARLY_OUT`=1, 3 ÷ 10 → q=0, r=3, latency 1. With `EARLY_OUT`=0, the same 3 ÷ 10 takes latency 34.
- **Handshake**: hold `out_ready` low for 5 cycles in DONE → outputs stable and `in_ready`=0 throughout. Raise `out_ready` → `in_ready`=1 next cycle. Issue a back-to-back second request → it is accepted on that cycle.
- **Flush**: flush in CALC at cycle 10 → IDLE next cycle, no `out_valid`. A following 9 ÷ 3 request returns q=3, r=0 unpolluted. Flush coinciding with `in_valid` → request not accepted.
- **Reset**: assert `rst` low asynchronously mid-CALC → IDLE and all outputs 0 without waiting for a clock edge. After release, `in_ready`=1.

Source files
------------

// File: rtl/ex_iter_div.sv
// Iterative radix-2 restoring divider for the EX stage: signed/unsigned, tagged,
// valid/ready on both sides, flushable, with early-out and a defined divide-by-zero result.
module ex_iter_div #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 4,
  parameter bit EARLY_OUT  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_signed,
  input  logic [DATA_WIDTH-1:0] in_dividend,
  input  logic [DATA_WIDTH-1:0] in_divisor,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_quotient,
  output logic [DATA_WIDTH-1:0] out_remainder,
  output logic [TAG_WIDTH-1:0]  out_tag,
  output logic                  out_div_by_zero,
  output logic                  busy,
  output logic [1:0]            dbg_state
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH) + 1;

  // Handshake: a transfer happens on a rising edge where valid and ready are both
  // high; valid never waits on ready, and the payload holds while valid is high.
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2, DONE = 2'd3} state_t;

  state_t         state, state_nxt;
  logic           op_signed, sd, sv;
  logic [W-1:0]   mag_b, rem, q_sr;
  logic [CW-1:0]  cnt;

  logic           accept, div_zero, early, neg_a, neg_b, last;
  logic [W-1:0]   mag_a_in, mag_b_in;
  logic [W:0]     rem_sh, trial;

  always_comb begin
    neg_a    = in_signed & in_dividend[W-1];
    neg_b    = in_signed & in_divisor[W-1];
    mag_a_in = neg_a ? -in_dividend : in_dividend;
    mag_b_in = neg_b ? -in_divisor  : in_divisor;
    accept   = in_valid & (state == IDLE) & ~flush;
    div_zero = (in_divisor == '0);
    early    = EARLY_OUT && (mag_a_in < mag_b_in);
    // rem < |b| keeps a negative trial within W+1 bits; its MSB is the borrow.
    rem_sh   = {rem, q_sr[W-1]};
    trial    = rem_sh - {1'b0, mag_b};
    last     = (cnt == CW'(W - 1));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = (div_zero || early) ? DONE : CALC;
      CALC: if (last) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_signed       <= 1'b0;
      sd              <= 1'b0;
      sv              <= 1'b0;
      mag_b           <= '0;
      rem             <= '0;
      q_sr            <= '0;
      cnt             <= '0;
      out_quotient    <= '0;
      out_remainder   <= '0;
      out_tag         <= '0;
      out_div_by_zero <= 1'b0;
    end else begin
      if (accept) begin
        op_signed       <= in_signed;
        sd              <= neg_a;
        sv              <= neg_b;
        mag_b           <= mag_b_in;
        rem             <= '0;
        q_sr            <= mag_a_in;
        cnt             <= '0;
        out_tag         <= in_tag;
        out_div_by_zero <= div_zero;
        // Shortcut results go straight to the output registers; the remainder is
        // the untouched dividend in both cases.
        if (div_zero) begin
          out_quotient  <= '1;
          out_remainder <= in_dividend;
        end else if (early) begin
          out_quotient  <= '0;
          out_remainder <= in_dividend;
        end
      end else if (state == CALC) begin
        rem  <= trial[W] ? rem_sh[W-1:0] : trial[W-1:0];
        q_sr <= {q_sr[W-2:0], ~trial[W]};
        cnt  <= cnt + CW'(1);
      end else if (state == FIX) begin
        out_quotient  <= (op_signed & (sd ^ sv)) ? -q_sr : q_sr;
        out_remainder <= (op_signed & sd) ? -rem : rem;
      end
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_ex_iter_div.sv
// Self-checking bench for ex_iter_div: directed vector table, handshake/flush/reset
// sequences, and randomized operations scored against an arithmetic reference model.
module tb_ex_iter_div;

  localparam int W    = 32;
  localparam int TW   = 4;
  localparam int EXPW = 2 * W + TW + 1 + 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          in_signed = 1'b0;
  logic [W-1:0]  in_dividend = '0;
  logic [W-1:0]  in_divisor = '0;
  logic [TW-1:0] in_tag = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_quotient, out_remainder;
  logic [TW-1:0] out_tag;
  logic          out_div_by_zero, busy;
  logic [1:0]    dbg_state;

  logic          in_valid_ne = 1'b0;
  logic          out_ready_ne = 1'b0;
  logic          in_ready_ne, out_valid_ne, dz_ne, busy_ne;
  logic [W-1:0]  q_ne, r_ne;
  logic [TW-1:0] tag_ne;
  logic [1:0]    dbg_ne;

  int n_checks = 0;
  int n_fail   = 0;
  logic [EXPW-1:0] exp_q[$];

  typedef struct {
    logic          sgn;
    logic [W-1:0]  a, b;
    logic [TW-1:0] tag;
    logic [W-1:0]  q, r;
    logic          dz;
    int            lat;
  } vec_t;
  vec_t vecs[9];

  ex_iter_div #(.DATA_WIDTH(W), .TAG_WIDTH(TW), .EARLY_OUT(1'b1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_signed(in_signed), .in_dividend(in_dividend), .in_divisor(in_divisor),
    .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .out_quotient(out_quotient), .out_remainder(out_remainder), .out_tag(out_tag),
    .out_div_by_zero(out_div_by_zero), .busy(busy), .dbg_state(dbg_state)
  );

  ex_iter_div #(.DATA_WIDTH(W), .TAG_WIDTH(TW), .EARLY_OUT(1'b0)) dut_ne (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid_ne), .in_ready(in_ready_ne),
    .in_signed(in_signed), .in_dividend(in_dividend), .in_divisor(in_divisor),
    .in_tag(in_tag), .out_valid(out_valid_ne), .out_ready(out_ready_ne),
    .out_quotient(q_ne), .out_remainder(r_ne), .out_tag(tag_ne),
    .out_div_by_zero(dz_ne), .busy(busy_ne), .dbg_state(dbg_ne)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer division on 64-bit values.
  function automatic logic [EXPW-1:0] model(input logic sgn, input logic [W-1:0] a,
                                           input logic [W-1:0] b, input logic [TW-1:0] tag);
    longint sa, sb, qq, rr, ma, mb;
    logic [W-1:0] q, r;
    logic dz;
    int lat;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'b0, a});
      sb = longint'({32'b0, b});
    end
    ma = (sa < 0) ? -sa : sa;
    mb = (sb < 0) ? -sb : sb;
    if (sb == 0) begin
      q = '1; r = a; dz = 1'b1; lat = 1;
    end else begin
      qq = sa / sb;
      rr = sa % sb;
      q  = qq[W-1:0];
      r  = rr[W-1:0];
      dz = 1'b0;
      lat = (ma < mb) ? 1 : W + 2;
    end
    return {q, r, tag, dz, 8'(lat)};
  endfunction

  // driver tasks
  task automatic issue(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [TW-1:0] tag, output int waited);
    waited = 0;
    @(negedge clk);
    in_signed = sgn; in_dividend = a; in_divisor = b; in_tag = tag; in_valid = 1'b1;
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic do_op(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [TW-1:0] tag, input int hold, output int waited);
    logic [EXPW-1:0] e;
    logic [W-1:0] eq, er;
    logic [TW-1:0] et;
    logic ed;
    logic [7:0] el;
    int lat;
    issue(sgn, a, b, tag, waited);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("result_valid", out_valid, 1);
    if (exp_q.size() == 0) begin
      check("exp_queue_nonempty", 0, 1);
      return;
    end
    e = exp_q.pop_front();
    {eq, er, et, ed, el} = e;
    check("quotient", out_quotient, eq);
    check("remainder", out_remainder, er);
    check("tag", out_tag, et);
    check("div_by_zero", out_div_by_zero, ed);
    check("latency", lat, el);
    check("in_ready_in_done", in_ready, 0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check("hold_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
      check("hold_quotient", out_quotient, eq);
      check("hold_remainder", out_remainder, er);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("in_ready_after_take", in_ready, 1);
    check("valid_after_take", out_valid, 0);
  endtask

  initial begin
    int waited, cnt, lat;
    logic sgn;
    logic [W-1:0] a, b;
    logic [TW-1:0] tag;

    vecs[0] = '{1'b0, 32'd100,        32'd7,          4'd3,  32'd14,         32'd2,          1'b0, 34};
    vecs[1] = '{1'b0, 32'hFFFFFFFF,   32'd1,          4'd5,  32'hFFFFFFFF,   32'd0,          1'b0, 34};
    vecs[2] = '{1'b1, 32'hFFFFFFF9,   32'd2,          4'd6,  32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0, 34};
    vecs[3] = '{1'b1, 32'd7,          32'hFFFFFFFE,   4'd7,  32'hFFFFFFFD,   32'd1,          1'b0, 34};
    vecs[4] = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   4'd8,  32'h80000000,   32'd0,          1'b0, 34};
    vecs[5] = '{1'b0, 32'd5,          32'd0,          4'd9,  32'hFFFFFFFF,   32'd5,          1'b1, 1};
    vecs[6] = '{1'b0, 32'd3,          32'd10,         4'd10, 32'd0,          32'd3,          1'b0, 1};
    vecs[7] = '{1'b1, 32'hFFFFFFFB,   32'd0,          4'd11, 32'hFFFFFFFF,   32'hFFFFFFFB,   1'b1, 1};
    vecs[8] = '{1'b1, 32'hFFFFFFFD,   32'd10,         4'd12, 32'd0,          32'hFFFFFFFD,   1'b0, 1};

    // reset
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_quotient", out_quotient, 0);
    check("reset_in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b1;

    // directed vector table
    foreach (vecs[i]) begin
      exp_q.push_back({vecs[i].q, vecs[i].r, vecs[i].tag, vecs[i].dz, 8'(vecs[i].lat)});
      do_op(vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].tag, 0, waited);
    end

    // backpressure then back-to-back accept
    exp_q.push_back(model(1'b0, 32'd1000, 32'd9, 4'd1));
    do_op(1'b0, 32'd1000, 32'd9, 4'd1, 5, waited);
    exp_q.push_back(model(1'b0, 32'd77, 32'd0, 4'd2));
    do_op(1'b0, 32'd77, 32'd0, 4'd2, 0, waited);
    check("back_to_back_wait", waited, 0);

    // early-out disabled: 3 / 10 takes the full path
    @(negedge clk);
    in_signed = 1'b0; in_dividend = 32'd3; in_divisor = 32'd10; in_tag = 4'd4;
    in_valid_ne = 1'b1;
    @(posedge clk);
    #1;
    in_valid_ne = 1'b0;
    lat = 1;
    while (!out_valid_ne && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("noearly_latency", lat, 34);
    check("noearly_quotient", q_ne, 0);
    check("noearly_remainder", r_ne, 3);
    out_ready_ne = 1'b1;
    @(posedge clk);
    #1;
    out_ready_ne = 1'b0;
    check("noearly_idle", busy_ne, 0);

    // flush mid-CALC, then a clean request
    issue(1'b0, 32'd12345, 32'd7, 4'd13, waited);
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_busy", busy, 0);
    check("flush_valid", out_valid, 0);
    cnt = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (out_valid) cnt++;
    end
    check("flush_no_result", cnt, 0);
    exp_q.push_back({32'd3, 32'd0, 4'd14, 1'b0, 8'd34});
    do_op(1'b0, 32'd9, 32'd3, 4'd14, 0, waited);

    // flush together with in_valid accepts nothing
    @(negedge clk);
    in_signed = 1'b0; in_dividend = 32'd50; in_divisor = 32'd5; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0; flush = 1'b0;
    check("flush_with_valid_busy", busy, 0);

    // asynchronous reset mid-CALC
    issue(1'b0, 32'd999, 32'd4, 4'd15, waited);
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("async_rst_busy", busy, 0);
    check("async_rst_valid", out_valid, 0);
    check("async_rst_quotient", out_quotient, 0);
    check("async_rst_remainder", out_remainder, 0);
    check("async_rst_tag", out_tag, 0);
    check("async_rst_dz", out_div_by_zero, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("post_rst_in_ready", in_ready, 1);

    // randomized operations against the model
    for (int n = 0; n < 40; n++) begin
      sgn = 1'($urandom_range(0, 1));
      a   = $urandom;
      b   = $urandom;
      tag = TW'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0: ;
        1: b = W'($urandom_range(1, 15));
        2: b = '0;
        default: a = W'($urandom_range(0, 20));
      endcase
      exp_q.push_back(model(sgn, a, b, tag));
      do_op(sgn, a, b, tag, $urandom_range(0, 2), waited);
    end

    check("exp_queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
